// File: rtl/muller_c_gate.sv
// -----------------------------------------------------------------------------
// muller_c_gate
//
// Clocked Muller C-element array. Each lane registers a C-element output:
// it goes high when request and ack are both 1, low when both are 0, and
// holds its value otherwise. It generates the next stage's request between
// handshake stages of a 4-phase request/ack pipeline. Per-lane rise/fall
// pulses and a wrapping transition counter are provided for monitoring.
//
// Optional feature (compile-time macro MULLER_C_SYNC_EN):
//   When defined, request and ack each pass through a 2-flop synchronizer
//   per lane. Input-to-next_request latency is then 3 rising edges instead
//   of 1.
//
// Parameters:
//   WIDTH    number of independent lanes
//   CNT_W    width of each lane's transition counter
//   INIT_VAL reset value of every next_request lane (0 or 1)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   request      request input per lane
//   ack          acknowledge input per lane
//   next_request registered C-element output per lane
//   rise_pulse   one-cycle pulse after a lane's next_request goes 0->1
//   fall_pulse   one-cycle pulse after a lane's next_request goes 1->0
//   trans_count  per-lane transition count, lane i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module muller_c_gate #(
   parameter int WIDTH    = 1,
   parameter int CNT_W    = 8,
   parameter int INIT_VAL = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       request,
   input  logic [WIDTH-1:0]       ack,
   output logic [WIDTH-1:0]       next_request,
   output logic [WIDTH-1:0]       rise_pulse,
   output logic [WIDTH-1:0]       fall_pulse,
   output logic [WIDTH*CNT_W-1:0] trans_count
);

   localparam logic INIT_BIT = (INIT_VAL != 0);

   // Effective inputs seen by the C-element logic.
   logic [WIDTH-1:0] req_eff;
   logic [WIDTH-1:0] ack_eff;

`ifdef MULLER_C_SYNC_EN
   logic [WIDTH-1:0] req_s1_q, req_s2_q;
   logic [WIDTH-1:0] ack_s1_q, ack_s2_q;

   // NOTE: sequential state is written with non-blocking assignments so that
   // every flop samples its source's pre-edge value, which is what makes the
   // two synchronizer stages a true 2-flop chain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_s1_q <= '0;
         req_s2_q <= '0;
         ack_s1_q <= '0;
         ack_s2_q <= '0;
      end else begin
         req_s1_q <= request;
         req_s2_q <= req_s1_q;
         ack_s1_q <= ack;
         ack_s2_q <= ack_s1_q;
      end
   end

   assign req_eff = req_s2_q;
   assign ack_eff = ack_s2_q;
`else
   assign req_eff = request;
   assign ack_eff = ack;
`endif

   logic [WIDTH-1:0]       nreq_q, nreq_d;
   logic [WIDTH-1:0]       rise_q, rise_d;
   logic [WIDTH-1:0]       fall_q, fall_d;
   logic [WIDTH*CNT_W-1:0] cnt_q,  cnt_d;
   logic [WIDTH-1:0]       changed;

   // C-element as a majority gate of request, ack and the current output:
   // both high sets, both low clears, disagreement keeps the old value.
   assign nreq_d  = (req_eff & ack_eff) | (nreq_q & (req_eff | ack_eff));
   assign changed = nreq_d ^ nreq_q;
   assign rise_d  = changed &  nreq_d;
   assign fall_d  = changed & ~nreq_d;

   // NOTE: cnt_d is given a full default before the loop so every bit is
   // assigned on every path and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(changed[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nreq_q <= {WIDTH{INIT_BIT}};
         rise_q <= '0;
         fall_q <= '0;
         cnt_q  <= '0;
      end else begin
         nreq_q <= nreq_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         cnt_q  <= cnt_d;
      end
   end

   assign next_request = nreq_q;
   assign rise_pulse   = rise_q;
   assign fall_pulse   = fall_q;
   assign trans_count  = cnt_q;

endmodule

// File: tb/tb_muller_c_gate.sv
// -----------------------------------------------------------------------------
// tb_muller_c_gate
//
// Directed testbench for muller_c_gate. Three instances share clock and
// reset: a 1-lane/8-bit-counter instance for the main handshake sequence and
// asynchronous reset, a 1-lane/2-bit-counter instance for counter wrap, and
// a 2-lane instance for lane independence. Latency follows MULLER_C_SYNC_EN.
// -----------------------------------------------------------------------------
module tb_muller_c_gate;

`ifdef MULLER_C_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic clk;
   logic rst_n;

   // Instance 1: WIDTH=1, CNT_W=8
   logic       req1, ack1, nr1, rp1, fp1;
   logic [7:0] tc1;
   // Instance 2: WIDTH=1, CNT_W=2
   logic       req2, ack2, nr2, rp2, fp2;
   logic [1:0] tc2;
   // Instance 3: WIDTH=2, CNT_W=4
   logic [1:0] req3, ack3, nr3, rp3, fp3;
   logic [7:0] tc3;

   int n_checks = 0;
   int n_fail   = 0;

   muller_c_gate #(.WIDTH(1), .CNT_W(8), .INIT_VAL(0)) u_dut1 (
      .clk(clk), .reset(rst_n), .request(req1), .ack(ack1),
      .next_request(nr1), .rise_pulse(rp1), .fall_pulse(fp1), .trans_count(tc1)
   );

   muller_c_gate #(.WIDTH(1), .CNT_W(2), .INIT_VAL(0)) u_dut2 (
      .clk(clk), .reset(rst_n), .request(req2), .ack(ack2),
      .next_request(nr2), .rise_pulse(rp2), .fall_pulse(fp2), .trans_count(tc2)
   );

   muller_c_gate #(.WIDTH(2), .CNT_W(4), .INIT_VAL(0)) u_dut3 (
      .clk(clk), .reset(rst_n), .request(req3), .ack(ack3),
      .next_request(nr3), .rise_pulse(rp3), .fall_pulse(fp3), .trans_count(tc3)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Inputs change at a falling edge; outputs are sampled at the falling edge
   // after the edge on which the change reaches next_request.
   task automatic settle();
      repeat (LAT) @(posedge clk);
      @(negedge clk);
   endtask

   // Main handshake sequence for instance 1: {request, ack, nr, rise, fall, count}
   typedef struct {
      logic       r;
      logic       a;
      logic       nr;
      logic       rp;
      logic       fp;
      logic [7:0] tc;
   } vec_t;

   vec_t seq[8];

   initial begin
      seq[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      seq[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      seq[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      seq[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1};
      seq[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
      seq[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
      seq[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
      seq[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};

      rst_n = 1'b0;
      req1 = 1'b0; ack1 = 1'b0;
      req2 = 1'b0; ack2 = 1'b0;
      req3 = 2'b00; ack3 = 2'b00;

      // Reset values while reset is held, with the clock running.
      #15;
      check("rst_nr",   32'(nr1), 0);
      check("rst_rise", 32'(rp1), 0);
      check("rst_fall", 32'(fp1), 0);
      check("rst_cnt",  32'(tc1), 0);

      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_nr",  32'(nr1), 0);
      check("post_rst_cnt", 32'(tc1), 0);

      // Handshake sequence with hold, set, clear and pulse behaviour.
      for (int i = 0; i < 8; i++) begin
         req1 = seq[i].r;
         ack1 = seq[i].a;
         settle();
         check($sformatf("seq%0d_nr", i),   32'(nr1), 32'(seq[i].nr));
         check($sformatf("seq%0d_rise", i), 32'(rp1), 32'(seq[i].rp));
         check($sformatf("seq%0d_fall", i), 32'(fp1), 32'(seq[i].fp));
         check($sformatf("seq%0d_cnt", i),  32'(tc1), 32'(seq[i].tc));
      end

      // Asynchronous reset mid-cycle clears next_request without a clock edge.
      req1 = 1'b1; ack1 = 1'b1;
      settle();
      check("pre_async_nr", 32'(nr1), 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_nr",  32'(nr1), 0);
      check("async_cnt", 32'(tc1), 0);
      req1 = 1'b1; ack1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      settle();
      settle();
      check("rel_hold_nr",   32'(nr1), 0);
      check("rel_hold_rise", 32'(rp1), 0);
      check("rel_hold_cnt",  32'(tc1), 0);

      // Counter wrap on the 2-bit counter instance.
      for (int k = 1; k <= 10; k++) begin
         req2 = (k % 2 == 1);
         ack2 = (k % 2 == 1);
         settle();
         check($sformatf("wrap%0d_cnt", k), 32'(tc2), 32'(k % 4));
         check($sformatf("wrap%0d_nr", k),  32'(nr2), 32'(k % 2));
      end

      // Lane independence on the 2-lane instance.
      req3 = 2'b11; ack3 = 2'b01;
      settle();
      check("lanes_a_nr",   32'(nr3), 32'b01);
      check("lanes_a_cnt0", 32'(tc3[3:0]), 1);
      check("lanes_a_cnt1", 32'(tc3[7:4]), 0);
      check("lanes_a_rise", 32'(rp3), 32'b01);
      req3 = 2'b11; ack3 = 2'b11;
      settle();
      check("lanes_b_nr",   32'(nr3), 32'b11);
      check("lanes_b_cnt0", 32'(tc3[3:0]), 1);
      check("lanes_b_cnt1", 32'(tc3[7:4]), 1);
      check("lanes_b_rise", 32'(rp3), 32'b10);

      // Latency: next_request must not move before LAT edges have passed.
      req1 = 1'b0; ack1 = 1'b0;
      settle();
      req1 = 1'b1; ack1 = 1'b1;
      for (int e = 1; e < LAT; e++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("lat_early%0d_nr", e), 32'(nr1), 0);
      end
      @(posedge clk);
      @(negedge clk);
      check("lat_nr", 32'(nr1), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
